regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 32x32 register file: configurable width, depth and number of read ports.
- Register 0 is hardwired to zero.
- Adds a per-register busy scoreboard so the decode stage can detect RAW/WAW hazards against in-flight writebacks.
- Sits between decode (issue/read) and writeback stages.

Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers (power of two, >=2); AW = log2(DEPTH)
- NUM_RD, 2, number of combinational read ports (1..4)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- rd_addr  input  NUM_RD*AW  packed read addresses; port k at bits [k*AW +: AW]
- rd_data  output  NUM_RD*WIDTH  packed read data; port k at bits [k*WIDTH +: WIDTH]
- rd_busy  output  NUM_RD  per-port: addressed register has a pending write
- wb_en  input  1  writeback strobe
- wb_addr  input  AW  writeback register
- wb_data  input  WIDTH  writeback data
- iss_valid  input  1  issue request: instruction will write iss_addr
- iss_addr  input  AW  destination register of issuing instruction
- iss_ready  output  1  issue accepted this cycle
- iss_err  output  1  registered pulse: previous cycle's issue was rejected
- busy_cnt  output  AW+1  number of registers currently busy

Behaviour:
- Reset (async, rst=1): all registers 0, all busy bits 0, iss_err=0, busy_cnt=0; takes effect immediately, regardless of clk.
- Reads are combinational, zero latency. rd_data[k] = mem[rd_addr[k]]. Address 0 always returns 0.
- Write: on posedge with wb_en=1 and wb_addr!=0, mem[wb_addr] <= wb_data. Writes to register 0 are discarded. Visible to reads the following cycle (see optional feature).
- Scoreboard busy[DEPTH], with busy[0] constant 0.
  - iss_ready = iss_valid & (iss_addr==0 | ~busy[iss_addr] | (wb_en & wb_addr==iss_addr)).
  - Accepted issue with iss_addr!=0 sets busy[iss_addr] next cycle.
  - wb_en clears busy[wb_addr] next cycle.
  - Same address issued and written back in one cycle: issue wins, busy stays/becomes 1; data is still written.
  - iss_valid with iss_ready=0: no state change, iss_err=1 the next cycle, else iss_err=0.
  - Writeback to a non-busy register is legal (untracked write): data is written, busy unchanged.
- rd_busy[k] = busy[rd_addr[k]], combinational. Reflects state before this cycle's edge.
- busy_cnt is registered and updated incrementally: +1 on set, -1 on clear, net 0 when both or neither apply. It always equals the popcount of busy. Maximum value DEPTH-1.
- Multiple read ports may address the same register; all return identical data.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding: if wb_en & wb_addr!=0 & rd_addr[k]==wb_addr, then rd_data[k]=wb_data in the same cycle.
  - rd_busy[k]=0 for that port in that cycle.
  - Register 0 is never forwarded.
- Undefined:
  - Reads return the pre-write value until the next cycle.
  - rd_busy reflects the stored busy bit.

Decomposition:
- Package regfile_pkg holds:
  - the clog2 function;
  - default WIDTH/DEPTH/NUM_RD constants;
  - REG_ZERO localparam (address 0).
- Sub-module regfile_scoreboard holds busy[], the iss_ready/iss_err logic and busy_cnt.
- Data array, read muxes and bypass stay in the top.

Test Plan:
- Assert rst mid-cycle after writing 0xDEADBEEF to r5 -> rd_data for r5 reads 0 immediately; busy_cnt=0; iss_err=0.
- wb_en, wb_addr=0, wb_data=0xFFFFFFFF; then read r0 -> 0. Issue r0 -> iss_ready=1, busy_cnt stays 0.
- Issue r7 -> next cycle rd_busy=1 on r7, busy_cnt=1. Re-issue r7 -> iss_ready=0, iss_err=1 next cycle. Writeback r7=0x1234 -> busy clears, busy_cnt=0, r7 reads 0x1234.
- Same cycle: issue r3 and writeback r3=0x55 -> r3=0x55, busy[r3]=1, busy_cnt=1.
- REGFILE_BYPASS_EN on: writeback r9=0xA5A5A5A5 while both ports read r9 -> both ports return 0xA5A5A5A5 in the same cycle. Off: both return the old value, new value next cycle.
- Issue r1..r31 back-to-back -> busy_cnt=31. Write all back in reverse order -> busy_cnt decrements to 0, never underflows.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Holds the default geometry, the hardwired-zero register address and clog2.
// No logic; imported by regfile_scoreboard and regfile_sb.
package regfile_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 2;

  // Register that always reads as zero and is never tracked as busy.
  localparam int REG_ZERO = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: tracks destinations of issued, not yet written-back instructions.
// Latency: iss_ready and raw_busy are combinational; busy bits, busy_cnt and iss_err update on the next edge.
// Backpressure: an issue to a busy register is refused (iss_ready=0) unless that register is written back this cycle.
// Ports: clk, rst (async high); rd_addr -> raw_busy per read port; wb_en/wb_addr clear busy;
//        iss_valid/iss_addr -> iss_ready, iss_err (registered reject pulse); busy_cnt = popcount of busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = DEF_NUM_RD,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    raw_busy,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr,
  output logic                 iss_ready,
  output logic                 iss_err,
  output logic [AW:0]          busy_cnt
);

  // Bit 0 has no storage so register 0 can never look busy.
  logic [DEPTH-1:1] busy_q;
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             wb_live;
  logic             set;
  logic             inc;
  logic             dec;
  logic [AW:0]      cnt_nxt;

  assign busy    = {busy_q, 1'b0};
  assign wb_live = wb_en && (wb_addr != AW'(REG_ZERO));

  // A writeback to the same register frees it in time for a back-to-back issue.
  assign iss_ready = iss_valid && ((iss_addr == AW'(REG_ZERO)) || !busy[iss_addr] ||
                                   (wb_en && (wb_addr == iss_addr)));
  assign set = iss_ready && (iss_addr != AW'(REG_ZERO));

  // Count actual bit transitions so the counter tracks popcount exactly:
  // re-setting an already busy bit, or clearing an idle one, changes nothing.
  assign inc = set && !busy[iss_addr];
  assign dec = wb_live && busy[wb_addr] && !(set && (iss_addr == wb_addr));

  always_comb begin
    busy_nxt = busy;
    if (wb_live) busy_nxt[wb_addr] = 1'b0;
    if (set)     busy_nxt[iss_addr] = 1'b1;  // issue wins over same-address writeback
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = busy_cnt;
    if (inc && !dec)      cnt_nxt = busy_cnt + (AW+1)'(1);
    else if (dec && !inc) cnt_nxt = busy_cnt - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      busy_cnt <= '0;
      iss_err  <= 1'b0;
    end else begin
      busy_q   <= busy_nxt[DEPTH-1:1];
      busy_cnt <= cnt_nxt;
      iss_err  <= iss_valid && !iss_ready;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
    assign raw_busy[k] = busy[rd_addr[k*AW +: AW]];
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file (r0 hardwired to zero) with busy scoreboard for RAW/WAW hazard detection.
// Latency: reads combinational; writes visible next cycle (same cycle when REGFILE_BYPASS_EN is defined).
// Backpressure: iss_ready deasserts for an issue to a busy register; iss_err pulses the cycle after a reject.
// Ports: clk, rst (async high); rd_addr/rd_data/rd_busy packed per read port; wb_en/wb_addr/wb_data writeback;
//        iss_valid/iss_addr/iss_ready/iss_err issue handshake; busy_cnt registers currently busy.
// Option: define REGFILE_BYPASS_EN to forward writeback data to same-cycle reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = DEF_NUM_RD,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic                    wb_en,
  input  logic [AW-1:0]           wb_addr,
  input  logic [WIDTH-1:0]        wb_data,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_addr,
  output logic                    iss_ready,
  output logic                    iss_err,
  output logic [AW:0]             busy_cnt
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [NUM_RD-1:0] raw_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wb_en && (wb_addr != AW'(REG_ZERO))) begin
      mem[wb_addr] <= wb_data;
    end
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .raw_busy  (raw_busy),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .iss_err   (iss_err),
    .busy_cnt  (busy_cnt)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          fwd;
    assign a = rd_addr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    // r0 is excluded so a discarded write never leaks onto a read.
    assign fwd = wb_en && (wb_addr != AW'(REG_ZERO)) && (a == wb_addr);
`else
    assign fwd = 1'b0;
`endif
    assign rd_data[k*WIDTH +: WIDTH] = (a == AW'(REG_ZERO)) ? '0 :
                                       fwd ? wb_data : mem[a];
    assign rd_busy[k] = raw_busy[k] && !fwd;
  end

endmodule
